// File: rtl/decoder_sweep_seq_if.sv
// decoder_sweep_seq_if
//   Bundles the decoder/sweep-sequencer signals so the block can be wired
//   as a single port. clk and reset stay outside the bundle.
//
//   en     direct-mode decode enable            (master -> slave)
//   s      direct-mode select, SEL_W bits       (master -> slave)
//   start  sweep request                        (master -> slave)
//   out    registered one-hot enables, 2**SEL_W (slave -> master)
//   busy   high while sweeping                  (slave -> master)
//   done   one-cycle sweep-complete pulse       (slave -> master)
//   idx    current sweep index, 0 outside sweep (slave -> master)

interface decoder_sweep_seq_if #(
  parameter int SEL_W = 5
);
  localparam int OUT_N = 2 ** SEL_W;

  logic             en;
  logic [SEL_W-1:0] s;
  logic             start;
  logic [OUT_N-1:0] out;
  logic             busy;
  logic             done;
  logic [SEL_W-1:0] idx;

  modport master (
    output en, s, start,
    input  out, busy, done, idx
  );

  modport slave (
    input  en, s, start,
    output out, busy, done, idx
  );
endinterface

// File: rtl/decoder_sweep_seq.sv
// decoder_sweep_seq
//   Registered one-hot write-enable decoder for the register file with a
//   built-in sweep sequencer used by the clear/scan logic.
//
//   Direct mode (IDLE): out <= en ? onehot(s) : 0, one cycle of latency.
//   Sweep mode: a start seen in IDLE walks out through every writable
//   index 0..L-1, holding each for DWELL cycles, then pulses done for one
//   cycle and returns to IDLE. With MASK_TOP=1 index OUT_N-1 (the zero
//   register) is never driven and is skipped by the sweep.
//
//   Ports
//     clk    rising-edge clock
//     reset  synchronous, active-high; aborts a sweep without a done pulse
//     bus    decoder_sweep_seq_if slave modport (en, s, start in;
//            out, busy, done, idx out)
//
//   Parameters
//     SEL_W     select width, OUT_N = 2**SEL_W outputs
//     MASK_TOP  1 = output OUT_N-1 forced low in every mode
//     DWELL     cycles each index is held during a sweep (>= 1)

module decoder_sweep_seq #(
  parameter int SEL_W    = 5,
  parameter int MASK_TOP = 1,
  parameter int DWELL    = 1
) (
  input  logic                clk,
  input  logic                reset,
  decoder_sweep_seq_if.slave  bus
);

  localparam int OUT_N = 2 ** SEL_W;
  // Number of indices visited by a sweep.
  localparam int L     = (MASK_TOP != 0) ? OUT_N - 1 : OUT_N;
  localparam int CNT_W = $clog2(DWELL + 1);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(L - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_N-1:0] out_q,   out_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [SEL_W-1:0] idx_q,   idx_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // One-hot decode with the optional top-index mask applied.
  function automatic logic [OUT_N-1:0] decode(input logic [SEL_W-1:0] sel);
    logic [OUT_N-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    if ((MASK_TOP != 0) && (sel == '1)) begin
      v = '0;
    end
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        // start outranks the direct-decode inputs.
        if (bus.start) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
          cnt_d   = '0;
          out_d   = decode('0);
          busy_d  = 1'b1;
        end else begin
          out_d  = bus.en ? decode(bus.s) : '0;
          busy_d = 1'b0;
          idx_d  = '0;
          cnt_d  = '0;
        end
      end

      ST_SWEEP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            out_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
            out_d = decode(idx_q + 1'b1);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        // Inputs are ignored here; decode resumes from the next IDLE edge.
        state_d = ST_IDLE;
        out_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        idx_d   = '0;
        cnt_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
        out_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.idx  = idx_q;

  // Structural invariants of the output encoding.
  a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(out_q));
  a_excl:   assert property (@(posedge clk) disable iff (reset) !(busy_q && done_q));
  a_mask:   assert property (@(posedge clk) disable iff (reset)
                             (MASK_TOP == 0) || !out_q[OUT_N-1]);

endmodule

// File: tb/tb_decoder_sweep_seq.sv
// Testbench for decoder_sweep_seq: three instances (SEL_W=3) share one
// stimulus stream and are checked every cycle against a schedule-based
// reference model.
//   u_a: MASK_TOP=1, DWELL=2
//   u_b: MASK_TOP=1, DWELL=1
//   u_c: MASK_TOP=0, DWELL=1

module tb_decoder_sweep_seq;

  typedef struct {
    logic [7:0] out;
    logic       busy;
    logic       done;
    logic [2:0] idx;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       en;
  logic [2:0] s;
  logic       start;

  int unsigned total;
  int unsigned bad;
  int unsigned cyc;

  int unsigned mask_cfg  [3] = '{1, 1, 0};
  int unsigned dwell_cfg [3] = '{2, 1, 1};

  // Remaining scheduled outputs of an accepted sweep, one entry per edge.
  exp_t pend [3][$];
  exp_t ex   [3];

  decoder_sweep_seq_if #(.SEL_W(3)) ifa ();
  decoder_sweep_seq_if #(.SEL_W(3)) ifb ();
  decoder_sweep_seq_if #(.SEL_W(3)) ifc ();

  assign ifa.en = en;  assign ifa.s = s;  assign ifa.start = start;
  assign ifb.en = en;  assign ifb.s = s;  assign ifb.start = start;
  assign ifc.en = en;  assign ifc.s = s;  assign ifc.start = start;

  decoder_sweep_seq #(.SEL_W(3), .MASK_TOP(1), .DWELL(2)) u_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  decoder_sweep_seq #(.SEL_W(3), .MASK_TOP(1), .DWELL(1)) u_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));
  decoder_sweep_seq #(.SEL_W(3), .MASK_TOP(0), .DWELL(1)) u_c (
    .clk(clk), .reset(reset), .bus(ifc.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  // Reference model: what the outputs must be after the edge just taken.
  task automatic model_edge(input int k);
    exp_t        e;
    logic [7:0]  one;
    logic [7:0]  o;
    int unsigned nidx;
    one  = 8'h01;
    nidx = (mask_cfg[k] != 0) ? 7 : 8;
    if (reset) begin
      pend[k].delete();
      ex[k] = '{out: 8'h00, busy: 1'b0, done: 1'b0, idx: 3'd0};
    end else begin
      if (pend[k].size() == 0 && start) begin
        for (int i = 0; i < int'(nidx); i++) begin
          for (int d = 0; d < int'(dwell_cfg[k]); d++) begin
            e.out  = one << i;
            e.busy = 1'b1;
            e.done = 1'b0;
            e.idx  = 3'(i);
            pend[k].push_back(e);
          end
        end
        pend[k].push_back('{out: 8'h00, busy: 1'b0, done: 1'b1, idx: 3'd0});
        pend[k].push_back('{out: 8'h00, busy: 1'b0, done: 1'b0, idx: 3'd0});
      end
      if (pend[k].size() != 0) begin
        ex[k] = pend[k].pop_front();
      end else begin
        o = 8'h00;
        if (en && !(mask_cfg[k] != 0 && s == 3'd7)) o[s] = 1'b1;
        ex[k] = '{out: o, busy: 1'b0, done: 1'b0, idx: 3'd0};
      end
    end
  endtask

  task automatic cmp_dut(input string nm, input int k, input logic [7:0] o,
                         input logic b, input logic d, input logic [2:0] i);
    check({nm, ".out"},  32'(o), 32'(ex[k].out));
    check({nm, ".busy"}, 32'(b), 32'(ex[k].busy));
    check({nm, ".done"}, 32'(d), 32'(ex[k].done));
    check({nm, ".idx"},  32'(i), 32'(ex[k].idx));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
    cyc++;
    cmp_dut("a", 0, ifa.out, ifa.busy, ifa.done, ifa.idx);
    cmp_dut("b", 1, ifb.out, ifb.busy, ifb.done, ifb.idx);
    cmp_dut("c", 2, ifc.out, ifc.busy, ifc.done, ifc.idx);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;

    // Reset held two cycles with every other input active.
    reset = 1'b1; en = 1'b1; s = 3'd3; start = 1'b1;
    tick();
    tick();
    check("rst.out", 32'(ifa.out), 32'h00);
    check("rst.busy", 32'(ifa.busy), 32'h0);
    reset = 1'b0; start = 1'b0;
    tick();
    check("post_rst.decode", 32'(ifa.out), 32'h08);

    // Direct decode over all selects, then disable.
    for (int i = 0; i < 8; i++) begin
      s = 3'(i);
      tick();
    end
    check("direct.masked7", 32'(ifb.out), 32'h00);
    check("direct.unmasked7", 32'(ifc.out), 32'h80);
    en = 1'b0;
    tick();
    check("direct.en0", 32'(ifa.out), 32'h00);

    // Single start pulse; let every instance finish.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 18; i++) tick();

    // start competes with en/s, then held high across whole sweeps.
    start = 1'b1; en = 1'b1; s = 3'd5;
    tick();
    check("prio.sweep_wins", 32'(ifa.out), 32'h01);
    for (int i = 0; i < 40; i++) tick();
    start = 1'b0; en = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    // Reset mid-sweep when the DWELL=1 instance reaches idx 3.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("midsweep.idx3", 32'(ifb.idx), 32'h3);
    reset = 1'b1;
    tick();
    check("abort.out", 32'(ifb.out), 32'h00);
    check("abort.done", 32'(ifb.done), 32'h0);
    reset = 1'b0; en = 1'b1; s = 3'd2;
    tick();
    check("abort.decode", 32'(ifb.out), 32'h04);
    en = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    // Unmasked sweep, then direct select of the top index.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    en = 1'b1; s = 3'd7;
    tick();
    check("unmasked.top", 32'(ifc.out), 32'h80);
    check("masked.top", 32'(ifb.out), 32'h00);
    en = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    // Randomized traffic, including occasional resets mid-sweep.
    for (int n = 0; n < 500; n++) begin
      en    = 1'($urandom_range(0, 1));
      s     = 3'($urandom_range(0, 7));
      start = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 1'b0; start = 1'b0; en = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_sweep_seq.md
Name: decoder_sweep_seq

Overview:
Parametrised, registered one-hot decoder with a built-in sweep sequencer. It is the next-generation write-enable decoder for the register file. In direct mode it decodes an SEL_W-bit select into 2**SEL_W registered enables. In sweep mode it walks the enables through every writable index, which the register-file clear/scan logic uses. An optional top-index mask keeps the zero register (X31) permanently unwritable.

Parameters:
SEL_W, 5, select width; OUT_N = 2**SEL_W outputs (derived localparam, not overridable)
MASK_TOP, 1, 1 = output index OUT_N-1 is forced 0 in every mode and skipped by the sweep
DWELL, 1, cycles each index is held during a sweep; legal range >= 1

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
en  input  1  direct-mode decode enable
s  input  SEL_W  direct-mode select
start  input  1  sweep request; sampled in IDLE only
out  output  OUT_N  registered one-hot enables (all-zero when inactive)
busy  output  1  high while in SWEEP
done  output  1  single-cycle pulse on sweep completion
idx  output  SEL_W  current sweep index; 0 outside SWEEP

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset).
- All outputs are registers. Reset (sampled at an edge) sets state=IDLE, out=0, busy=0, done=0, idx=0 and clears the dwell counter.
- Reset has priority over every other input, including mid-sweep: the sweep is aborted and no done pulse is produced.
- States: IDLE, SWEEP, DONE.
- IDLE, start=0:
  - out <= en ? onehot(s) : 0, i.e. 1-cycle latency from s/en to out.
  - If MASK_TOP=1 and s==OUT_N-1, out <= 0.
- IDLE, start=1:
  - start has priority over en/s.
  - State <= SWEEP, idx <= 0, dwell counter <= 0, out <= onehot(0), busy <= 1.
- SWEEP:
  - en, s and start are ignored. Holding start high does not retrigger.
  - out = onehot(idx), held for DWELL cycles. The dwell counter width is clog2(DWELL+1).
  - On the final dwell cycle of a non-last index: idx <= idx+1 and out <= onehot(idx+1).
  - Last index is L-1, where L = MASK_TOP ? OUT_N-1 : OUT_N.
  - On the final dwell cycle of the last index: state <= DONE, out <= 0, busy <= 0, done <= 1, idx <= 0.
  - busy is high for exactly L*DWELL consecutive cycles.
- DONE:
  - Lasts exactly one cycle: done=1, out=0, busy=0.
  - start, en and s are ignored. The next state is IDLE with done <= 0.
  - Direct decode resumes in that IDLE cycle, so its out reflects en/s sampled at the IDLE edge.
- Invariants:
  - out is one-hot or all-zero at all times.
  - out[OUT_N-1] never rises when MASK_TOP=1.
  - busy and done are never both high.
- Out-of-range select cannot occur, since s spans exactly OUT_N codes.
- Widths: idx increments in SEL_W bits. It never wraps, because the sweep stops at L-1 <= OUT_N-1.

Test Plan:
1. Reset. Config SEL_W=3. Hold reset 2 cycles with en=1, s=3, start=1 -> out=8'h00, busy=0, done=0, idx=0 throughout. First cycle after release with start=0 -> direct decode active.
2. Direct decode. Config SEL_W=3, MASK_TOP=1. Drive en=1 with s=0..7 on successive cycles -> out one cycle later is 01,02,04,08,10,20,40,00 (index 7 masked). Then en=0 -> out=00 next cycle.
3. Sweep. Config SEL_W=3, MASK_TOP=1, DWELL=2. Pulse start one cycle ->
   - out = 01,01,02,02,04,04,08,08,10,10,20,20,40,40;
   - busy=1 for 14 cycles, idx stepping 0..6;
   - then one cycle of out=00, done=1, busy=0;
   - then IDLE.
4. Priority and retrigger. In IDLE, drive start=1 with en=1, s=5 -> next out=01 (sweep wins, not 20). Keep start high for the whole sweep -> exactly one sweep and one done pulse, no retrigger in DONE. After return to IDLE with start still high -> a new sweep starts (legal).
5. Reset mid-sweep. Config DWELL=1. Assert reset when idx=3 -> next cycle out=00, busy=0, idx=0, and no done pulse ever appears. After release, en=1, s=2 -> out=04 one cycle later.
6. Unmasked variant. Config SEL_W=3, MASK_TOP=0, DWELL=1.
   - Sweep -> out 01..80 over 8 busy cycles, then done.
   - Direct en=1, s=7 -> out=80.
